// File: rtl/fp_pkg.sv
// Shared single-precision float constants, FSM encoding and pack/unpack helpers
// for the accumulator and the future fp adder.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_ZERO = 32'h0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    function automatic fp_t fp_unpack(input logic [31:0] w);
        return fp_t'(w);
    endfunction

    function automatic logic [31:0] fp_pack(input fp_t f);
        return 32'(f);
    endfunction

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
    endfunction
endpackage

// File: rtl/fp_accumulator_if.sv
// Operand stream in and result stream out of the accumulator, valid/ready on both sides.
interface fp_accumulator_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns W when the vector is all zeros.
module fp_lzc #(
    parameter int W = 28,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_cnt
);
    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) o_cnt = CW'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fp_accumulator.sv
// Sequential float32 accumulator: IDLE -> ALIGN -> ADD -> NORM per operand, DONE holds the
// sum until it is taken. Rounding is truncation; denormals flush to zero.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int GUARD_BITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    fp_accumulator_if.slave bus
);
    localparam int SW = 24 + GUARD_BITS;
    localparam int AW = SW + 1;
    localparam int LW = $clog2(AW + 1);

    logic [2:0]       r_state;
    logic [31:0]      r_acc;
    logic [31:0]      r_op;
    logic             r_last;
    logic             r_sign_big;
    logic             r_sign_small;
    logic             r_sign_res;
    logic [EXP_W-1:0] r_exp;
    logic [SW-1:0]    r_m_big;
    logic [SW-1:0]    r_m_small;
    logic [AW-1:0]    r_sum;
    logic             r_spec;
    logic [31:0]      r_spec_val;

    fp_t              w_a;
    fp_t              w_b;
    logic [SW-1:0]    w_sig_a;
    logic [SW-1:0]    w_sig_b;
    logic             w_a_big;
    logic [EXP_W-1:0] w_diff;
    logic [SW-1:0]    w_sig_big;
    logic [SW-1:0]    w_sig_sml;
    logic             w_a_inf;
    logic             w_b_inf;
    logic [31:0]      w_spec_val;

    assign w_a       = fp_unpack(r_acc);
    assign w_b       = fp_unpack(r_op);
    assign w_sig_a   = (w_a.exp == '0) ? '0 : {1'b1, w_a.man, {GUARD_BITS{1'b0}}};
    assign w_sig_b   = (w_b.exp == '0) ? '0 : {1'b1, w_b.man, {GUARD_BITS{1'b0}}};
    assign w_a_big   = w_a.exp >= w_b.exp;
    assign w_diff    = w_a_big ? (w_a.exp - w_b.exp) : (w_b.exp - w_a.exp);
    assign w_sig_big = w_a_big ? w_sig_a : w_sig_b;
    assign w_sig_sml = (w_diff >= EXP_W'(SW)) ? '0 : ((w_a_big ? w_sig_b : w_sig_a) >> w_diff);
    assign w_a_inf   = w_a.exp == EXP_W'(EXP_MAX);
    assign w_b_inf   = w_b.exp == EXP_W'(EXP_MAX);

    // An infinite accumulator passes through unchanged; only opposite infinities make NaN.
    always_comb begin
        w_spec_val = r_acc;
        if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) w_spec_val = QNAN;
        else if (!w_a_inf) w_spec_val = fp_inf(w_b.sign);
    end

    logic          w_same;
    logic          w_big_ge;
    logic [AW-1:0] w_sum;
    logic          w_sign_res;

    assign w_same     = r_sign_big == r_sign_small;
    assign w_big_ge   = r_m_big >= r_m_small;
    assign w_sign_res = (w_same || w_big_ge) ? r_sign_big : r_sign_small;

    always_comb begin
        if (w_same)        w_sum = {1'b0, r_m_big} + {1'b0, r_m_small};
        else if (w_big_ge) w_sum = {1'b0, r_m_big - r_m_small};
        else               w_sum = {1'b0, r_m_small - r_m_big};
    end

    logic [LW-1:0]       w_lz;
    logic [MAN_W-1:0]    w_man;
    logic signed [9:0]   w_exp_n;
    logic [31:0]         w_res;

    fp_lzc #(.W(AW)) u_lzc (
        .i_vec (r_sum),
        .o_cnt (w_lz)
    );

    // Leading one lands on the hidden-bit position, which the MAN_W cast then drops.
    always_comb begin
        if (r_sum[AW-1]) begin
            w_man   = MAN_W'(r_sum >> (GUARD_BITS + 1));
            w_exp_n = $signed({2'b00, r_exp}) + 10'sd1;
        end else begin
            w_man   = MAN_W'((r_sum << (w_lz - LW'(1))) >> GUARD_BITS);
            w_exp_n = $signed({2'b00, r_exp}) - $signed({{(10 - LW){1'b0}}, w_lz}) + 10'sd1;
        end
        w_res = fp_pack('{sign: r_sign_res, exp: w_exp_n[EXP_W-1:0], man: w_man});
        if (r_spec)                             w_res = r_spec_val;
        else if (r_sum == '0)                   w_res = POS_ZERO;
        else if (w_exp_n >= 10'sd255)           w_res = fp_inf(r_sign_res);
        else if (w_exp_n <= 10'sd0)             w_res = POS_ZERO;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_acc        <= POS_ZERO;
            r_op         <= '0;
            r_last       <= 1'b0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_sign_res   <= 1'b0;
            r_exp        <= '0;
            r_m_big      <= '0;
            r_m_small    <= '0;
            r_sum        <= '0;
            r_spec       <= 1'b0;
            r_spec_val   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op    <= bus.in_data;
                        r_last  <= bus.in_last;
                        r_state <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_exp        <= w_a_big ? w_a.exp : w_b.exp;
                    r_sign_big   <= w_a_big ? w_a.sign : w_b.sign;
                    r_sign_small <= w_a_big ? w_b.sign : w_a.sign;
                    r_m_big      <= w_sig_big;
                    r_m_small    <= w_sig_sml;
                    r_spec       <= w_a_inf || w_b_inf;
                    r_spec_val   <= w_spec_val;
                    r_state      <= ADD;
                end
                ADD: begin
                    r_sum      <= w_sum;
                    r_sign_res <= w_sign_res;
                    r_state    <= NORM;
                end
                NORM: begin
                    r_acc   <= w_res;
                    r_state <= r_last ? DONE : IDLE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_acc   <= POS_ZERO;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.out_data  = (r_state == DONE) ? r_acc : POS_ZERO;
endmodule

// File: tb/tb_fp_accumulator.sv
// Table-driven bench for fp_accumulator with an expected-result queue,
// plus hand sequences for mid-operation reset and output backpressure.
module tb_fp_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_accumulator_if bus();

    fp_accumulator #(.GUARD_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        int          n;
        logic [31:0] ops [3];
        logic [31:0] res;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic set_vec(input int idx, input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] res, input string name);
        vecs[idx].n      = n;
        vecs[idx].ops[0] = a;
        vecs[idx].ops[1] = b;
        vecs[idx].ops[2] = c;
        vecs[idx].res    = res;
        vecs[idx].name   = name;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l, input bit chk_rdy);
        int t = 0;
        int low = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_last  = 1'b0;
        if (chk_rdy) begin
            while (!bus.in_ready && low < 10) begin
                low++;
                @(posedge clk); #1;
            end
            check("in_ready_low_cycles", 32'(low), 32'd3);
        end
    endtask

    // Called one step after the last transfer edge; out_valid must be visible after
    // three more edges so that it is high on the fourth.
    task automatic get_result(input string name);
        int cnt = 0;
        logic [31:0] req;
        while (!bus.out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        req = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFFFFFF;
        check({name, "_latency"}, 32'(cnt), 32'd3);
        check(name, bus.out_data, req);
        @(posedge clk); #1;
        check({name, "_handoff_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, "_handoff_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_seq(input int i);
        for (int k = 0; k < vecs[i].n; k++) begin
            if (k == vecs[i].n - 1) sb_q.push_back(vecs[i].res);
            send(vecs[i].ops[k], k == vecs[i].n - 1, k != vecs[i].n - 1);
        end
        get_result(vecs[i].name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [31:0] req;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        set_vec(0,  3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000, "sum_1_2_3");
        set_vec(1,  1, 32'hC1DA4000, 32'h0,        32'h0,        32'hC1DA4000, "single_term");
        set_vec(2,  2, 32'h40A00000, 32'hC0A00000, 32'h0,        32'h00000000, "cancel");
        set_vec(3,  2, 32'h4B800000, 32'h3F800000, 32'h0,        32'h4B800000, "trunc_lost");
        set_vec(4,  2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        32'h7F800000, "overflow");
        set_vec(5,  2, 32'h7F800000, 32'hFF800000, 32'h0,        32'h7FC00000, "inf_minus_inf");
        set_vec(6,  1, 32'h00400000, 32'h0,        32'h0,        32'h00000000, "denorm_flush");
        set_vec(7,  2, 32'h3FC00000, 32'hBE800000, 32'h0,        32'h3FA00000, "sub_align");
        set_vec(8,  2, 32'h00800000, 32'h80C00000, 32'h0,        32'h00000000, "underflow");
        set_vec(9,  2, 32'h3F800000, 32'hFF800000, 32'h0,        32'hFF800000, "neg_inf");
        set_vec(10, 2, 32'h3F800000, 32'hC0400000, 32'h0,        32'hC0000000, "neg_result");

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_out_data",  bus.out_data,           32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_seq(i);

        // Reset while the first operand is in ADD must leave no residue.
        send(32'h40000000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("mid_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("mid_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        sb_q.push_back(32'h3F800000);
        send(32'h3F800000, 1'b1, 1'b0);
        get_result("after_reset");

        // Hold the result in DONE while an operand is offered.
        bus.out_ready = 1'b0;
        send(32'h40000000, 1'b0, 1'b1);
        sb_q.push_back(32'h40A00000);
        send(32'h40400000, 1'b1, 1'b0);
        cnt = 0;
        while (!bus.out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'd3);
        req = sb_q.pop_front();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F800000;
        bus.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data",  bus.out_data,           req);
            check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_release_data", bus.out_data, req);
        @(posedge clk); #1;
        check("bp_after_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("bp_after_in_ready", {31'd0, bus.in_ready},  32'd1);
        sb_q.push_back(32'h3F800000);
        send(32'h3F800000, 1'b1, 1'b0);
        get_result("after_bp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
